// File: rtl/reg_list_sequencer_pkg.sv
// reg_list_sequencer_pkg
//   Shared control-unit definitions for the load/store-multiple register
//   list sequencer: FSM state encoding, the address-width derivation and
//   a population-count helper.
package reg_list_sequencer_pkg;

  // State encoding values, kept as localparams so other control-unit
  // blocks can decode the sequencer state if they need to.
  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_EMIT_ENC = 2'd1;
  localparam logic [1:0] ST_DONE_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_EMIT = ST_EMIT_ENC,
    ST_DONE = ST_DONE_ENC
  } seq_state_t;

  // Widest register file the helpers below are sized for.
  localparam int MAX_REGS = 64;

  // Bits needed to index n registers (never less than one bit).
  function automatic int addr_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i <= 6; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  // Number of set bits in a list, zero-extended to MAX_REGS.
  function automatic int popcount(input logic [MAX_REGS-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < MAX_REGS; i++) begin
      if (v[i]) c = c + 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/reg_list_sequencer_bit_priority_encoder.sv
// bit_priority_encoder
//   Purely combinational priority encoder over a bitmask.
//   Ports:
//     mask        in   WIDTH   bits to search
//     dir         in   1       0 = report lowest set bit, 1 = highest
//     index       out  IDX_W   position of the selected bit (0 if none)
//     any         out  1       at least one bit of mask is set
//     onehot_last out  1       exactly one bit of mask is set
module bit_priority_encoder #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) (
  input  logic [WIDTH-1:0] mask,
  input  logic             dir,
  output logic [IDX_W-1:0] index,
  output logic             any,
  output logic             onehot_last
);

  always_comb begin
    index = '0;
    if (dir) begin
      // Walk upward so the highest set bit is the last one written.
      for (int i = 0; i < WIDTH; i++) begin
        if (mask[i]) index = IDX_W'(i);
      end
    end else begin
      // Walk downward so the lowest set bit is the last one written.
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (mask[i]) index = IDX_W'(i);
      end
    end
  end

  assign any = |mask;
  // Clearing the lowest set bit leaves zero only for a single-bit mask.
  assign onehot_last = any && ((mask & (mask - WIDTH'(1))) == '0);

endmodule

// File: rtl/reg_list_sequencer.sv
// reg_list_sequencer
//   Sequencer for load/store-multiple instructions. Latches a register
//   bitmask on start and emits the index of each set bit, one per accepted
//   handshake, in ascending or descending order, then pulses done.
//   Ports:
//     clk          in   1         system clock
//     reset        in   1         synchronous active-high reset
//     start        in   1         begin sequencing (honoured in IDLE only)
//     reg_list     in   NUM_REGS  register bitmask, sampled with start
//     descending   in   1         0 = lowest first, 1 = highest first
//     advance      in   1         consumer accepts current address
//     valid        out  1         address/ordinal/first/last meaningful
//     reg_address  out  ADDR_W    index of current register
//     ordinal      out  ADDR_W+1  0-based position in the sequence
//     first        out  1         current element is first of the list
//     last         out  1         current element is last of the list
//     count        out  ADDR_W+1  popcount of latched list
//     busy         out  1         high in EMIT and DONE
//     done         out  1         one-cycle pulse at end of sequence
module reg_list_sequencer
  import reg_list_sequencer_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = addr_width(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [NUM_REGS-1:0] reg_list,
  input  logic                descending,
  input  logic                advance,
  output logic                valid,
  output logic [ADDR_W-1:0]   reg_address,
  output logic [ADDR_W:0]     ordinal,
  output logic                first,
  output logic                last,
  output logic [ADDR_W:0]     count,
  output logic                busy,
  output logic                done
);

  seq_state_t          r_state;
  seq_state_t          w_state_next;
  logic [NUM_REGS-1:0] r_mask;
  logic                r_dir;
  logic [ADDR_W:0]     r_ordinal;
  logic [ADDR_W:0]     r_count;

  logic [ADDR_W-1:0]   w_index;
  logic                w_any;
  logic                w_onehot_last;
  logic [MAX_REGS-1:0] w_list_ext;
  logic [NUM_REGS-1:0] w_clear_bit;
  logic                w_emit;

  bit_priority_encoder #(
    .WIDTH (NUM_REGS),
    .IDX_W (ADDR_W)
  ) u_prio (
    .mask        (r_mask),
    .dir         (r_dir),
    .index       (w_index),
    .any         (w_any),
    .onehot_last (w_onehot_last)
  );

  // Zero-extend the incoming list to the width the popcount helper takes.
  always_comb begin
    w_list_ext                 = '0;
    w_list_ext[NUM_REGS-1:0]   = reg_list;
  end

  assign w_clear_bit = NUM_REGS'(1) << w_index;
  assign w_emit      = (r_state == ST_EMIT);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_next = (reg_list != '0) ? ST_EMIT : ST_DONE;
      end
      ST_EMIT: begin
        if (advance && w_onehot_last) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath: latch the list on start, retire one bit per accepted address.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask    <= '0;
      r_dir     <= 1'b0;
      r_ordinal <= '0;
      r_count   <= '0;
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_mask    <= reg_list;
        r_dir     <= descending;
        r_count   <= (ADDR_W+1)'(popcount(w_list_ext));
        r_ordinal <= '0;
      end else if (w_emit && advance) begin
        r_mask    <= r_mask & ~w_clear_bit;
        r_ordinal <= r_ordinal + 1'b1;
      end
    end
  end

  // All outputs come from registered state; reg_list never reaches them
  // combinationally.
  assign valid       = w_emit && w_any;
  assign reg_address = valid ? w_index : '0;
  assign ordinal     = r_ordinal;
  assign first       = valid && (r_ordinal == '0);
  assign last        = valid && w_onehot_last;
  assign count       = r_count;
  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_DONE);

endmodule

// File: tb/tb_reg_list_sequencer.sv
module tb_reg_list_sequencer;

  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;

  logic                clk;
  logic                reset;
  logic                start;
  logic [NUM_REGS-1:0] reg_list;
  logic                descending;
  logic                advance;
  logic                valid;
  logic [ADDR_W-1:0]   reg_address;
  logic [ADDR_W:0]     ordinal;
  logic                first;
  logic                last;
  logic [ADDR_W:0]     count;
  logic                busy;
  logic                done;

  int total;
  int bad;

  reg_list_sequencer #(
    .NUM_REGS (NUM_REGS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .reg_list    (reg_list),
    .descending  (descending),
    .advance     (advance),
    .valid       (valid),
    .reg_address (reg_address),
    .ordinal     (ordinal),
    .first       (first),
    .last        (last),
    .count       (count),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs driven 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check one emitted element in the current cycle.
  task automatic check_elem(input string tag, input int addr, input int ord,
                            input bit f, input bit l, input int cnt);
    check({tag, ".valid"}, 32'(valid), 32'd1);
    check({tag, ".addr"}, 32'(reg_address), 32'(addr));
    check({tag, ".ord"}, 32'(ordinal), 32'(ord));
    check({tag, ".first"}, 32'(first), 32'(f));
    check({tag, ".last"}, 32'(last), 32'(l));
    check({tag, ".count"}, 32'(count), 32'(cnt));
    check({tag, ".busy"}, 32'(busy), 32'd1);
    check({tag, ".done"}, 32'(done), 32'd0);
  endtask

  // Pulse start with the given list for one cycle (cycle N).
  task automatic kick(input logic [NUM_REGS-1:0] lst, input bit desc);
    start      = 1'b1;
    reg_list   = lst;
    descending = desc;
    step();
    start      = 1'b0;
    reg_list   = 16'h0000;
    descending = 1'b0;
  endtask

  int exp_asc[4];
  int exp_desc[4];

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    start      = 1'b0;
    reg_list   = '0;
    descending = 1'b0;
    advance    = 1'b0;
    exp_asc    = '{0, 5, 10, 15};
    exp_desc   = '{15, 10, 5, 0};

    step();
    step();
    check("rst.valid", 32'(valid), 32'd0);
    check("rst.addr", 32'(reg_address), 32'd0);
    check("rst.ord", 32'(ordinal), 32'd0);
    check("rst.first", 32'(first), 32'd0);
    check("rst.last", 32'(last), 32'd0);
    check("rst.count", 32'(count), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    reset = 1'b0;
    step();
    check("idle.busy", 32'(busy), 32'd0);

    // Ascending 8421, advance held high.
    advance = 1'b1;
    kick(16'h8421, 1'b0);
    for (int k = 0; k < 4; k++) begin
      $display("asc element %0d: addr=%0d ord=%0d", k, reg_address, ordinal);
      check_elem("asc", exp_asc[k], k, k == 0, k == 3, 4);
      step();
    end
    check("asc.done", 32'(done), 32'd1);
    check("asc.dvalid", 32'(valid), 32'd0);
    check("asc.dbusy", 32'(busy), 32'd1);
    step();
    check("asc.done_off", 32'(done), 32'd0);
    check("asc.idle", 32'(busy), 32'd0);

    // Descending 8421.
    kick(16'h8421, 1'b1);
    for (int k = 0; k < 4; k++) begin
      $display("desc element %0d: addr=%0d ord=%0d", k, reg_address, ordinal);
      check_elem("desc", exp_desc[k], k, k == 0, k == 3, 4);
      step();
    end
    check("desc.done", 32'(done), 32'd1);
    step();
    check("desc.done_off", 32'(done), 32'd0);

    // Empty list.
    kick(16'h0000, 1'b0);
    $display("empty: busy=%0d done=%0d", busy, done);
    check("empty.valid", 32'(valid), 32'd0);
    check("empty.busy", 32'(busy), 32'd1);
    check("empty.done", 32'(done), 32'd1);
    check("empty.count", 32'(count), 32'd0);
    step();
    check("empty.idle", 32'(busy), 32'd0);
    check("empty.done_off", 32'(done), 32'd0);
    check("empty.valid2", 32'(valid), 32'd0);

    // Full list, each address held for two cycles.
    advance = 1'b0;
    kick(16'hFFFF, 1'b0);
    for (int k = 0; k < 16; k++) begin
      advance = 1'b0;
      check_elem("full.hold", k, k, k == 0, k == 15, 16);
      step();
      advance = 1'b1;
      check_elem("full.acc", k, k, k == 0, k == 15, 16);
      $display("full element %0d: addr=%0d count=%0d", k, reg_address, count);
      step();
    end
    advance = 1'b0;
    check("full.done", 32'(done), 32'd1);
    check("full.count", 32'(count), 32'd16);
    step();
    check("full.idle", 32'(busy), 32'd0);

    // Reset mid-sequence on 00F0 while address 5 is valid.
    advance = 1'b1;
    kick(16'h00F0, 1'b0);
    check_elem("rmid.a4", 4, 0, 1'b1, 1'b0, 4);
    step();
    check_elem("rmid.a5", 5, 1, 1'b0, 1'b0, 4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    $display("mid reset: busy=%0d valid=%0d count=%0d", busy, valid, count);
    check("rmid.valid", 32'(valid), 32'd0);
    check("rmid.busy", 32'(busy), 32'd0);
    check("rmid.count", 32'(count), 32'd0);
    check("rmid.ord", 32'(ordinal), 32'd0);
    check("rmid.done", 32'(done), 32'd0);
    step();
    check("rmid.done2", 32'(done), 32'd0);
    kick(16'h0003, 1'b0);
    check_elem("rnew.a0", 0, 0, 1'b1, 1'b0, 2);
    step();
    check_elem("rnew.a1", 1, 1, 1'b0, 1'b1, 2);
    step();
    check("rnew.done", 32'(done), 32'd1);
    step();

    // Start during EMIT and DONE must be ignored.
    advance = 1'b0;
    kick(16'h0101, 1'b0);
    check_elem("ign.a0", 0, 0, 1'b1, 1'b0, 2);
    start      = 1'b1;
    reg_list   = 16'hF000;
    descending = 1'b1;
    step();
    start      = 1'b0;
    reg_list   = 16'h0000;
    descending = 1'b0;
    check_elem("ign.hold", 0, 0, 1'b1, 1'b0, 2);
    advance = 1'b1;
    step();
    check_elem("ign.a8", 8, 1, 1'b0, 1'b1, 2);
    step();
    advance = 1'b0;
    check("ign.done", 32'(done), 32'd1);
    start    = 1'b1;
    reg_list = 16'h0010;
    step();
    start    = 1'b0;
    reg_list = 16'h0000;
    check("ign.dstart_busy", 32'(busy), 32'd0);
    check("ign.dstart_valid", 32'(valid), 32'd0);
    check("ign.count_held", 32'(count), 32'd2);

    // Advance outside EMIT does nothing.
    advance = 1'b1;
    step();
    check("idle.adv_busy", 32'(busy), 32'd0);
    check("idle.adv_ord", 32'(ordinal), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
